uart_tx_sched: RTL and testbench

Transmit scheduler that shares the single UART transmitter among `N_REQ` byte-stream requesters. It arbitrates round-robin, supports a per-requester lock for multi-byte frames, and drives the UART's `idata`/`newTxData` handshake. It monitors `txBusy`, so each accepted byte is issued exactly once. The block sits between the command/response producers and the UART core, in the same clock domain.

---
 rtl/uart_ctrl_pkg.sv | 15 +
 rtl/uart_tx_sched_if.sv | 9 +
 rtl/uart_rr_pick.sv | 28 ++
 rtl/uart_tx_sched.sv | 113 +++++++++++
 tb/tb_uart_tx_sched.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_DONE = 2'd2
   } tx_state_t;

   localparam int DEF_N_REQ       = 4;
   localparam int DEF_TIMEOUT_CYC = 4096;
   // Clocks per UART bit; the UART core uses the same value.
   localparam int UART_BIT_TAU    = 104;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Handshake between the transmit scheduler (master) and the UART core (slave).
interface uart_tx_sched_if;
   logic [7:0] uart_idata;
   logic       uart_newTxData;
   logic       uart_txBusy;

   modport master (output uart_idata, output uart_newTxData, input  uart_txBusy);
   modport slave  (input  uart_idata, input  uart_newTxData, output uart_txBusy);
endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set bit of (req & mask) at or after start.
module uart_rr_pick #(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [N-1:0]  mask,
   input  logic [IW-1:0] start,
   output logic          found,
   output logic [IW-1:0] winner
);

   logic [IW-1:0] idx;

   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = start;
      for (int i = 0; i < N; i++) begin
         if (!found && req[idx] && mask[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
         idx = (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among N_REQ byte requesters: round-robin with
// per-requester lock, single-issue handshake against txBusy, issue timeout.
module uart_tx_sched
   import uart_ctrl_pkg::*;
#(
   parameter  int N_REQ       = DEF_N_REQ,
   parameter  int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   localparam int IW          = $clog2(N_REQ),
   localparam int TW          = $clog2(TIMEOUT_CYC)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ-1:0][7:0]      req_data,
   input  logic [N_REQ-1:0]           req_lock,
   output logic [N_REQ-1:0]           req_ready,
   uart_tx_sched_if.master            uart_bus,
   output logic [IW-1:0]              grant_id,
   output logic                       busy,
   output logic                       err_timeout,
   output logic [15:0]                tx_count
);

   tx_state_t     state;
   logic          lock_vld;
   logic [IW-1:0] lock_owner;
   logic [TW-1:0] tmo_cnt;

   logic               lock_active;
   logic [N_REQ-1:0]   pick_mask;
   logic [IW-1:0]      pick_start;
   logic               pick_found;
   logic [IW-1:0]      pick_idx;

   // A live lock narrows eligibility to its owner; everyone else stalls.
   always_comb begin
      lock_active = lock_vld && req_lock[lock_owner];
      pick_mask   = '1;
      if (lock_active) begin
         pick_mask             = '0;
         pick_mask[lock_owner] = 1'b1;
      end
      pick_start = (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
   end

   uart_rr_pick #(.N(N_REQ)) u_pick (
      .req    (req_valid),
      .mask   (pick_mask),
      .start  (pick_start),
      .found  (pick_found),
      .winner (pick_idx)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state                   <= ST_IDLE;
         req_ready               <= '0;
         uart_bus.uart_idata     <= '0;
         uart_bus.uart_newTxData <= 1'b0;
         grant_id                <= IW'(N_REQ - 1);
         busy                    <= 1'b0;
         err_timeout             <= 1'b0;
         tx_count                <= '0;
         lock_vld                <= 1'b0;
         lock_owner              <= '0;
         tmo_cnt                 <= '0;
      end else begin
         req_ready   <= '0;
         err_timeout <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (lock_vld && !req_lock[lock_owner])
                  lock_vld <= 1'b0;
               if (pick_found) begin
                  uart_bus.uart_idata     <= req_data[pick_idx];
                  uart_bus.uart_newTxData <= 1'b1;
                  grant_id                <= pick_idx;
                  req_ready[pick_idx]     <= 1'b1;
                  busy                    <= 1'b1;
                  lock_vld                <= req_lock[pick_idx];
                  lock_owner              <= pick_idx;
                  tmo_cnt                 <= '0;
                  state                   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               // txBusy is checked first so a same-cycle expiry is not an error.
               if (uart_bus.uart_txBusy) begin
                  uart_bus.uart_newTxData <= 1'b0;
                  state                   <= ST_WAIT_DONE;
               end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                  uart_bus.uart_newTxData <= 1'b0;
                  err_timeout             <= 1'b1;
                  lock_vld                <= 1'b0;
                  busy                    <= 1'b0;
                  state                   <= ST_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            ST_WAIT_DONE: begin
               if (!uart_bus.uart_txBusy) begin
                  tx_count <= tx_count + 1'b1;
                  busy     <= 1'b0;
                  state    <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a small behavioural UART transmitter.
module tb_uart_tx_sched;

   localparam int FRAME = 6;

   logic             clk = 1'b0;
   logic             reset;
   logic [3:0]       req_valid, req_lock, req_ready;
   logic [3:0][7:0]  req_data;
   logic [1:0]       grant_id;
   logic             busy, err_timeout;
   logic [15:0]      tx_count;

   uart_tx_sched_if u ();

   uart_tx_sched #(.N_REQ(4), .TIMEOUT_CYC(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_lock    (req_lock),
      .req_ready   (req_ready),
      .uart_bus    (u.master),
      .grant_id    (grant_id),
      .busy        (busy),
      .err_timeout (err_timeout),
      .tx_count    (tx_count)
   );

   always #5 clk = ~clk;

   // UART model: samples newTxData when idle, raises txBusy 2 cycles later for FRAME cycles.
   logic rx_hold = 1'b0, uart_dead = 1'b0, force_busy = 1'b0;
   int   ucnt = 0;
   logic [7:0] fr_q[$];
   int   err_seen = 0;
   int   acc_seen = 0;

   always @(posedge clk) begin
      if (ucnt != 0) ucnt <= ucnt - 1;
      else if (u.uart_newTxData && !rx_hold && !uart_dead) begin
         ucnt <= 2 + FRAME;
         fr_q.push_back(u.uart_idata);
      end
      if (err_timeout) err_seen <= err_seen + 1;
      if (req_ready != 4'b0) acc_seen <= acc_seen + 1;
   end
   assign u.uart_txBusy = force_busy | (ucnt != 0 && ucnt <= FRAME);

   int total = 0, bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy !== 1'b0 && n < 300) begin
         tick();
         n++;
      end
      chk(tag, 32'(n < 300), 1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, req_ready, 0);
      chk({tag, "_idata"}, u.uart_idata, 0);
      chk({tag, "_newtx"}, u.uart_newTxData, 0);
      chk({tag, "_grant"}, grant_id, 3);
      chk({tag, "_busy"},  busy, 0);
      chk({tag, "_err"},   err_timeout, 0);
      chk({tag, "_cnt"},   tx_count, 0);
   endtask

   initial begin
      int n, n2, cyc, fr_base, acc_base;
      logic [3:0] exp_rdy [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [3:0] lk_rdy  [4] = '{4'b0100, 4'b0100, 4'b0100, 4'b0001};
      logic [7:0] lk_dat  [4] = '{8'h21, 8'h22, 8'h23, 8'h40};

      reset = 1'b1; req_valid = '0; req_lock = '0; req_data = '0;
      tick(); tick();
      chk_reset_vals("rst");
      reset = 1'b0;

      // Single byte from requester 1
      req_data[1] = 8'hA5; req_valid = 4'b0010;
      tick();
      chk("single_ready", req_ready, 4'b0010);
      chk("single_newtx", u.uart_newTxData, 1);
      chk("single_busy",  busy, 1);
      chk("single_idata", u.uart_idata, 8'hA5);
      req_valid = '0;
      tick();
      chk("single_ready_1cyc", req_ready, 0);
      wait_idle("single_idle");
      chk("single_cnt",    tx_count, 1);
      chk("single_grant",  grant_id, 1);
      chk("single_frames", fr_q.size(), 1);
      chk("single_byte",   fr_q[0], 8'hA5);

      // Fairness: all four valid from a fresh reset
      reset = 1'b1; tick(); reset = 1'b0;
      chk("rst2_grant", grant_id, 3);
      chk("rst2_cnt",   tx_count, 0);
      fr_q.delete();
      acc_base = acc_seen;
      req_data = {8'h13, 8'h12, 8'h11, 8'h10};
      req_valid = 4'b1111;
      n = 0; cyc = 0;
      while (n < 5 && cyc < 500) begin
         tick(); cyc++;
         if (req_ready != 4'b0) begin
            chk($sformatf("rr_ready%0d", n), req_ready, exp_rdy[n]);
            n++;
         end
      end
      chk("rr_bound", 32'(cyc < 500), 1);
      req_valid = '0;
      wait_idle("rr_idle");
      chk("rr_cnt",    tx_count, 5);
      chk("rr_accept", acc_seen - acc_base, 5);
      chk("rr_frames", fr_q.size(), 5);
      for (int i = 0; i < 5 && i < fr_q.size(); i++)
         chk($sformatf("rr_byte%0d", i), fr_q[i], 8'h10 + (i % 4));

      // Lock: requester 2 streams three bytes while requester 0 waits
      fr_base = fr_q.size();
      req_data[2] = 8'h21; req_data[0] = 8'h40;
      req_lock = 4'b0100; req_valid = 4'b0101;
      n = 0; n2 = 0; cyc = 0;
      while (n < 4 && cyc < 500) begin
         tick(); cyc++;
         if (req_ready != 4'b0) begin
            chk($sformatf("lock_ready%0d", n), req_ready, lk_rdy[n]);
            chk($sformatf("lock_idata%0d", n), u.uart_idata, lk_dat[n]);
            n++;
            if (req_ready == 4'b0100) begin
               n2++;
               if (n2 == 3) begin req_lock[2] = 1'b0; req_valid[2] = 1'b0; end
               else req_data[2] = 8'h21 + 8'(n2);
            end else req_valid = '0;
         end
      end
      chk("lock_bound", 32'(cyc < 500), 1);
      req_valid = '0; req_lock = '0;
      wait_idle("lock_idle");
      chk("lock_cnt",    tx_count, 9);
      chk("lock_frames", fr_q.size() - fr_base, 4);

      // RX collision: UART ignores the request until reception ends
      fr_base = fr_q.size();
      rx_hold = 1'b1;
      req_data[3] = 8'h3C; req_valid = 4'b1000;
      tick();
      chk("rx_ready", req_ready, 4'b1000);
      req_valid = '0;
      repeat (8) tick();
      chk("rx_newtx_held", u.uart_newTxData, 1);
      chk("rx_idata_held", u.uart_idata, 8'h3C);
      chk("rx_no_frame",   fr_q.size() - fr_base, 0);
      rx_hold = 1'b0;
      wait_idle("rx_idle");
      chk("rx_frames", fr_q.size() - fr_base, 1);
      chk("rx_byte",   fr_q[fr_q.size()-1], 8'h3C);
      chk("rx_cnt",    tx_count, 10);
      chk("rx_no_err", err_seen, 0);

      // Timeout: UART never goes busy
      uart_dead = 1'b1;
      req_data[1] = 8'h77; req_valid = 4'b0010;
      tick();
      chk("tmo_ready", req_ready, 4'b0010);
      req_valid = '0;
      repeat (15) tick();
      chk("tmo_err_early", err_timeout, 0);
      chk("tmo_newtx_hold", u.uart_newTxData, 1);
      tick();
      chk("tmo_err",   err_timeout, 1);
      chk("tmo_busy",  busy, 0);
      chk("tmo_newtx", u.uart_newTxData, 0);
      chk("tmo_cnt",   tx_count, 10);
      tick();
      chk("tmo_err_1cyc", err_timeout, 0);

      // txBusy rises on the same edge the timeout would expire
      req_data[0] = 8'h55; req_valid = 4'b0001;
      tick();
      chk("tie_ready", req_ready, 4'b0001);
      req_valid = '0;
      repeat (15) tick();
      force_busy = 1'b1;
      tick();
      chk("tie_err",   err_timeout, 0);
      chk("tie_newtx", u.uart_newTxData, 0);
      chk("tie_busy",  busy, 1);
      force_busy = 1'b0;
      tick();
      chk("tie_done", busy, 0);
      chk("tie_cnt",  tx_count, 11);
      chk("tie_errs", err_seen, 1);

      // Reset mid-ISSUE
      req_data[2] = 8'h99; req_valid = 4'b0100;
      tick();
      chk("mid_ready", req_ready, 4'b0100);
      repeat (3) tick();
      chk("mid_newtx", u.uart_newTxData, 1);
      reset = 1'b1; req_valid = '0;
      tick();
      chk_reset_vals("mid_rst");
      reset = 1'b0;
      uart_dead = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
